// File: rtl/seq_addsub_unit.sv
// Multi-cycle adder/subtractor: processes a WIDTH-bit operand pair DIGIT bits per clock,
// LSB digit first, with a carry/borrow link register and registered status flags.
module seq_addsub_unit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             mode_r;
    logic             link;
    logic             link_next;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] da;
    logic [DIGIT-1:0] db;
    logic [DIGIT:0]   sum;
    logic             last;
    logic             ovf_next;

    // Subtraction runs as A + ~B + ~borrow; the link register always holds the
    // borrow in sub mode, so the carry out of the digit adder is inverted back.
    always_comb begin
        da = '0;
        db = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (cnt == CW'(k)) begin
                da = opa[k*DIGIT +: DIGIT];
                db = opb[k*DIGIT +: DIGIT];
            end
        end
        sum = {1'b0, da} + {1'b0, (mode_r ? ~db : db)}
            + {{DIGIT{1'b0}}, (mode_r ? ~link : link)};
        link_next = mode_r ? ~sum[DIGIT] : sum[DIGIT];
        acc_next = acc;
        for (int unsigned k = 0; k < N; k++) begin
            if (cnt == CW'(k)) begin
                acc_next[k*DIGIT +: DIGIT] = sum[DIGIT-1:0];
            end
        end
        last = (cnt == CW'(N - 1));
        if (mode_r) begin
            ovf_next = (opa[WIDTH-1] != opb[WIDTH-1]) && (acc_next[WIDTH-1] != opa[WIDTH-1]);
        end else begin
            ovf_next = (opa[WIDTH-1] == opb[WIDTH-1]) && (acc_next[WIDTH-1] != opa[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            mode_r <= 1'b0;
            link   <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa    <= a;
                        opb    <= b;
                        mode_r <= mode;
                        link   <= cin;
                        cnt    <= '0;
                        acc    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    link <= link_next;
                    cnt  <= cnt + 1'b1;
                    if (last) begin
                        result <= acc_next;
                        cout   <= link_next;
                        ovf    <= ovf_next;
                        zero   <= (acc_next == '0);
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Self-checking bench for seq_addsub_unit: directed vector table, handshake/reset
// sequences and randomized operations against an arithmetic reference model.
module tb_seq_addsub_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_s = 1'b0;
    logic        cin_s = 1'b0;
    logic [31:0] a_s = '0;
    logic [31:0] b_s = '0;
    logic [2:0]  st = '0;
    logic [2:0]  dn, by, co, ov, zr;
    logic [31:0] r32;
    logic [7:0]  r8;
    logic [15:0] r16;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    seq_addsub_unit #(.WIDTH(32), .DIGIT(8)) u32 (
        .clk(clk), .rst(rst), .start(st[0]), .mode(mode_s), .a(a_s), .b(b_s), .cin(cin_s),
        .busy(by[0]), .done(dn[0]), .result(r32), .cout(co[0]), .ovf(ov[0]), .zero(zr[0]));
    seq_addsub_unit #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .rst(rst), .start(st[1]), .mode(mode_s), .a(a_s[7:0]), .b(b_s[7:0]), .cin(cin_s),
        .busy(by[1]), .done(dn[1]), .result(r8), .cout(co[1]), .ovf(ov[1]), .zero(zr[1]));
    seq_addsub_unit #(.WIDTH(16), .DIGIT(16)) u16 (
        .clk(clk), .rst(rst), .start(st[2]), .mode(mode_s), .a(a_s[15:0]), .b(b_s[15:0]), .cin(cin_s),
        .busy(by[2]), .done(dn[2]), .result(r16), .cout(co[2]), .ovf(ov[2]), .zero(zr[2]));

    typedef struct {
        bit          m;
        logic [31:0] a;
        logic [31:0] b;
        bit          c;
        logic [31:0] r;
        bit          co;
        bit          ov;
        bit          z;
    } vec_t;

    int wid[3] = '{32, 8, 16};
    int nd[3]  = '{4, 8, 1};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] outs(input int sel);
        logic [31:0] r;
        case (sel)
            0:       r = r32;
            1:       r = {24'd0, r8};
            default: r = {16'd0, r16};
        endcase
        return {co[sel], ov[sel], zr[sel], r};
    endfunction

    // Reference: plain wide arithmetic, masked to the operand width.
    function automatic logic [34:0] model(input int w, input bit m, input logic [31:0] x,
                                          input logic [31:0] y, input bit c);
        logic [63:0] mask, xx, yy, full;
        logic [31:0] r;
        bit          cy, o, sa, sb, sr;
        mask = (64'd1 << w) - 64'd1;
        xx = {32'd0, x} & mask;
        yy = {32'd0, y} & mask;
        if (!m) begin
            full = xx + yy + 64'(c);
            cy = full[w];
        end else begin
            full = xx - yy - 64'(c);
            cy = (xx < yy + 64'(c));
        end
        r = 32'(full & mask);
        sa = xx[w-1];
        sb = yy[w-1];
        sr = r[w-1];
        o = m ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
        return {cy, o, (r == 32'd0), r};
    endfunction

    // Issues one operation from idle; returns outputs at done and accept->done latency.
    task automatic run_op(input int sel, input bit m, input logic [31:0] x, input logic [31:0] y,
                          input bit c, output logic [34:0] got, output int lat);
        logic [34:0] prev;
        bit          held;
        prev = outs(sel);
        held = 1'b1;
        mode_s = m; a_s = x; b_s = y; cin_s = c;
        st[sel] = 1'b1;
        @(posedge clk); #1;
        st[sel] = 1'b0;
        mode_s = ~m; a_s = $urandom; b_s = $urandom; cin_s = ~c;
        check("busy_after_accept", by[sel], 1);
        lat = 0;
        while (!dn[sel] && lat < 100) begin
            if (outs(sel) !== prev) held = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, nd[sel]);
        check("outputs_held_during_run", held, 1);
        check("busy_with_done", by[sel], 1);
        got = outs(sel);
        @(posedge clk); #1;
        check("busy_done_fall", {by[sel], dn[sel]}, 0);
    endtask

    vec_t        vt[8];
    logic [34:0] got, exp;
    int          lat, pulses;
    bit          m, c;
    logic [31:0] x, y;

    initial begin
        vt[0] = '{1'b1, 32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[3] = '{1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[4] = '{1'b1, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vt[5] = '{1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vt[6] = '{1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        vt[7] = '{1'b1, 32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0};

        // Reset state, including reset winning over a simultaneous start.
        st = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        st = '0;
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("reset_outputs", outs(s), 0);
            check("reset_busy_done", {by[s], dn[s]}, 0);
        end

        for (int i = 0; i < 8; i++) begin
            run_op(0, vt[i].m, vt[i].a, vt[i].b, vt[i].c, got, lat);
            check($sformatf("vec%0d", i), got, {vt[i].co, vt[i].ov, vt[i].z, vt[i].r});
        end

        // Bit-serial width: 0x80 - 0x01.
        run_op(1, 1'b1, 32'h80, 32'h01, 1'b0, got, lat);
        check("w8_sub", got, {1'b0, 1'b1, 1'b0, 32'h7F});

        // start pulses during RUN and DONE are ignored.
        mode_s = 1'b0; a_s = 32'd1; b_s = 32'd1; cin_s = 1'b0;
        st[0] = 1'b1;
        @(posedge clk); #1;
        a_s = 32'd9; b_s = 32'd9;
        pulses = 0;
        lat = 0;
        while (!dn[0] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (dn[0]) pulses++;
        check("hs_busy_with_done", by[0], 1);
        @(posedge clk); #1;
        st[0] = 1'b0;
        check("hs_busy_falls", {by[0], dn[0]}, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (dn[0]) pulses++;
        end
        check("hs_done_pulses", pulses, 1);
        check("hs_result", outs(0), {3'b000, 32'd2});

        // Reset two cycles after accept aborts the operation.
        mode_s = 1'b1; a_s = 32'hF0; b_s = 32'h0F; cin_s = 1'b0;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_outputs", outs(0), 0);
        check("abort_busy_done", {by[0], dn[0]}, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (dn[0]) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run_op(0, 1'b0, 32'h12345678, 32'h11111111, 1'b1, got, lat);
        check("after_abort", got, {3'b000, 32'h2345678A});

        // Randomized operations on all three geometries.
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 30; i++) begin
                m = 1'($urandom_range(0, 1));
                c = 1'($urandom_range(0, 1));
                x = $urandom;
                case ($urandom_range(0, 3))
                    0:       y = x;
                    1:       y = 32'hFFFFFFFF;
                    default: y = $urandom;
                endcase
                if (y == x) c = 1'b0;
                run_op(s, m, x, y, c, got, lat);
                exp = model(wid[s], m, x, y, c);
                check($sformatf("rand_u%0d_%0d", wid[s], i), got, exp);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
